// File: rtl/time_field_editor_pkg.sv
// time_edit_pkg: shared constants, state enum and calendar helper for the
// watch set-mode editor.
//   F_YEAR..F_SEC  cursor / field positions 0..5
//   SLOT_COMMIT    cursor position of the commit/cancel slot
//   F_NONE         "no field" marker for display characters that never blank
//   ASC_*          LCD character codes
//   dim()          days in a month, leap-aware on the two-digit year
package time_edit_pkg;

  localparam logic [2:0] F_YEAR      = 3'd0;
  localparam logic [2:0] F_MONTH     = 3'd1;
  localparam logic [2:0] F_DAY       = 3'd2;
  localparam logic [2:0] F_HOUR      = 3'd3;
  localparam logic [2:0] F_MIN       = 3'd4;
  localparam logic [2:0] F_SEC       = 3'd5;
  localparam logic [2:0] SLOT_COMMIT = 3'd6;
  localparam logic [2:0] F_NONE      = 3'd7;

  localparam logic [7:0] ASC_NUL    = 8'h00;
  localparam logic [7:0] ASC_SPACE  = 8'h20;
  localparam logic [7:0] ASC_ZERO   = 8'h30;
  localparam logic [7:0] ASC_TWO    = 8'h32;
  localparam logic [7:0] ASC_D      = 8'h44;
  localparam logic [7:0] ASC_E      = 8'h45;
  localparam logic [7:0] ASC_H      = 8'h48;
  localparam logic [7:0] ASC_I      = 8'h49;
  localparam logic [7:0] ASC_M      = 8'h4D;
  localparam logic [7:0] ASC_S      = 8'h53;
  localparam logic [7:0] ASC_T      = 8'h54;
  localparam logic [7:0] ASC_Y      = 8'h59;
  localparam logic [7:0] ASC_COMMIT = 8'hAE;

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } edit_state_t;

  // Two-digit years are 2000-based, so every multiple of 4 (including 00)
  // is a leap year within the representable range.
  function automatic logic [4:0] dim(input logic [3:0] month,
                                     input logic [1:0] year_lsb);
    case (month)
      4'd2:                    dim = (year_lsb == 2'd0) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      default:                 dim = 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/time_field_editor_key_repeat.sv
// edit_key_repeat: turns one debounced key level into action pulses.
//   clk     system clock
//   rst     synchronous active-high reset
//   key     debounced key level
//   solo    high when this key is the only key pressed
//   action  combinational pulse, acted on at the coming clk edge
// First action on the rising edge of (key & solo); after REPEAT_DELAY held
// cycles, one more action every REPEAT_PERIOD cycles.
module edit_key_repeat
  #(
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000
  ) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic solo,
    output logic action
  );

  logic        live;
  logic        live_q;
  logic [23:0] cnt;

  assign live = key & solo;

  // cnt reaching zero marks the terminal count of whichever interval runs.
  always_comb begin
    action = 1'b0;
    if (live && !live_q) begin
      action = 1'b1;
    end else if (live && cnt == 24'd0) begin
      action = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= 1'b0;
      cnt    <= 24'd0;
    end else begin
      live_q <= live;
      if (!live) begin
        cnt <= 24'd0;
      end else if (!live_q) begin
        cnt <= REPEAT_DELAY - 24'd1;
      end else if (cnt == 24'd0) begin
        cnt <= REPEAT_PERIOD - 24'd1;
      end else begin
        cnt <= cnt - 24'd1;
      end
    end
  end

endmodule

// File: rtl/time_field_editor.sv
// time_field_editor: watch date/time set-mode editor and LCD frame renderer.
//   clk         system clock
//   rst         synchronous active-high reset
//   blink_tick  1 Hz strobe, toggles the blink phase
//   edit_req    enter edit mode, snapshotting live_time
//   live_time   {year,month,day,hour,minute,second} from the timekeeper
//   key_*       debounced key levels (right/left move cursor, up/down edit)
//   index       LCD character index 0..31
//   bin_time    last committed time, same packing as live_time
//   en_time     one-cycle load strobe to the timekeeper
//   editing     high while in EDIT
//   cursor      0=year..5=second, 6=commit slot
//   out         registered character for index
//
// state | meaning
// IDLE  | showing live_time, waiting for edit_req
// EDIT  | editing snapshot; up/down at slot 6 commits/cancels
module time_field_editor
  import time_edit_pkg::*;
  #(
    parameter int          FIELD_W       = 8,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000,
    parameter int          HOUR_MAX      = 23
  ) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   blink_tick,
    input  logic                   edit_req,
    input  logic [6*FIELD_W-1:0]   live_time,
    input  logic                   key_right,
    input  logic                   key_left,
    input  logic                   key_up,
    input  logic                   key_down,
    input  logic [4:0]             index,
    output logic [6*FIELD_W-1:0]   bin_time,
    output logic                   en_time,
    output logic                   editing,
    output logic [2:0]             cursor,
    output logic [7:0]             out
  );

  localparam logic [FIELD_W-1:0] V_0    = '0;
  localparam logic [FIELD_W-1:0] V_1    = FIELD_W'(1);
  localparam logic [FIELD_W-1:0] V_10   = FIELD_W'(10);
  localparam logic [FIELD_W-1:0] V_12   = FIELD_W'(12);
  localparam logic [FIELD_W-1:0] V_59   = FIELD_W'(59);
  localparam logic [FIELD_W-1:0] V_99   = FIELD_W'(99);
  localparam logic [FIELD_W-1:0] V_HMAX = FIELD_W'(HOUR_MAX);

  edit_state_t state, state_nx;

  logic [FIELD_W-1:0] fld    [0:5];
  logic [FIELD_W-1:0] fld_nx [0:5];
  logic [FIELD_W-1:0] live_f [0:5];
  logic [FIELD_W-1:0] view   [0:5];
  logic [6*FIELD_W-1:0] fld_packed;

  logic [3:0] keys;
  logic       solo;
  logic       act_r, act_l, act_u, act_d, any_act;
  logic       do_commit, load;
  logic       phase;

  logic [2:0]         cur_f;
  logic [FIELD_W-1:0] cur_v, lo_v, hi_v, up_v, dn_v, new_dim;

  logic [2:0]         dsel, blk_f;
  logic               dig_en, dig_ones;
  logic [FIELD_W-1:0] dval, dig_v;
  logic [7:0]         ch;

  // ---------------------------------------------------------------- keys
  assign keys    = {key_down, key_up, key_left, key_right};
  assign solo    = (keys != 4'd0) && ((keys & (keys - 4'd1)) == 4'd0);
  assign any_act = act_r | act_l | act_u | act_d;

  edit_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_rep_right (.clk(clk), .rst(rst), .key(key_right), .solo(solo), .action(act_r));
  edit_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_rep_left  (.clk(clk), .rst(rst), .key(key_left),  .solo(solo), .action(act_l));
  edit_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_rep_up    (.clk(clk), .rst(rst), .key(key_up),    .solo(solo), .action(act_u));
  edit_key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_rep_down  (.clk(clk), .rst(rst), .key(key_down),  .solo(solo), .action(act_d));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    do_commit = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (edit_req) begin
          state_nx = EDIT;
          load     = 1'b1;
        end
      end
      EDIT: begin
        if (cursor == SLOT_COMMIT) begin
          if (act_u) begin
            state_nx  = IDLE;
            do_commit = 1'b1;
          end else if (act_d) begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign editing = (state == EDIT);

  // ---------------------------------------------------------------- field arithmetic
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      live_f[i] = live_time[(5-i)*FIELD_W +: FIELD_W];
    end
    fld_packed = {fld[0], fld[1], fld[2], fld[3], fld[4], fld[5]};
  end

  always_comb begin
    cur_f = (cursor < SLOT_COMMIT) ? cursor : F_SEC;
    cur_v = fld[cur_f];
    lo_v  = V_0;
    hi_v  = V_59;
    case (cur_f)
      F_YEAR:  begin lo_v = V_0; hi_v = V_99;   end
      F_MONTH: begin lo_v = V_1; hi_v = V_12;   end
      F_DAY:   begin
        lo_v = V_1;
        hi_v = FIELD_W'(dim(fld[F_MONTH][3:0], fld[F_YEAR][1:0]));
      end
      F_HOUR:  begin lo_v = V_0; hi_v = V_HMAX; end
      default: begin lo_v = V_0; hi_v = V_59;   end
    endcase

    // >= / > keep out-of-range snapshots (e.g. a bad live day) recoverable.
    up_v = (cur_v >= hi_v) ? lo_v : cur_v + V_1;
    dn_v = (cur_v <= lo_v || cur_v > hi_v) ? hi_v : cur_v - V_1;

    for (int i = 0; i < 6; i++) begin
      fld_nx[i] = fld[i];
    end
    if (act_u) begin
      fld_nx[cur_f] = up_v;
    end else if (act_d) begin
      fld_nx[cur_f] = dn_v;
    end

    // Month/year edits can shrink the month; pull the day in on the same edge.
    new_dim = FIELD_W'(dim(fld_nx[F_MONTH][3:0], fld_nx[F_YEAR][1:0]));
    if ((cur_f == F_YEAR || cur_f == F_MONTH) && fld_nx[F_DAY] > new_dim) begin
      fld_nx[F_DAY] = new_dim;
    end
  end

  // ---------------------------------------------------------------- display
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      view[i] = (state == EDIT) ? fld[i] : live_f[i];
    end

    ch       = ASC_SPACE;
    dsel     = F_YEAR;
    dig_en   = 1'b0;
    dig_ones = 1'b0;
    blk_f    = F_NONE;
    case (index)
      5'd0:  ch = ASC_S;
      5'd1:  ch = ASC_E;
      5'd2:  ch = ASC_T;
      5'd5:  begin ch = ASC_TWO;  blk_f = F_YEAR; end
      5'd6:  begin ch = ASC_ZERO; blk_f = F_YEAR; end
      5'd7:  begin dig_en = 1'b1; dsel = F_YEAR;  blk_f = F_YEAR;  end
      5'd8:  begin dig_en = 1'b1; dig_ones = 1'b1; dsel = F_YEAR;  blk_f = F_YEAR;  end
      5'd9:  ch = ASC_Y;
      5'd10: begin dig_en = 1'b1; dsel = F_MONTH; blk_f = F_MONTH; end
      5'd11: begin dig_en = 1'b1; dig_ones = 1'b1; dsel = F_MONTH; blk_f = F_MONTH; end
      5'd12: ch = ASC_M;
      5'd13: begin dig_en = 1'b1; dsel = F_DAY;   blk_f = F_DAY;   end
      5'd14: begin dig_en = 1'b1; dig_ones = 1'b1; dsel = F_DAY;   blk_f = F_DAY;   end
      5'd15: ch = ASC_D;
      5'd16: ch = ASC_T;
      5'd17: ch = ASC_I;
      5'd18: ch = ASC_M;
      5'd19: ch = ASC_E;
      5'd21: begin dig_en = 1'b1; dsel = F_HOUR;  blk_f = F_HOUR;  end
      5'd22: begin dig_en = 1'b1; dig_ones = 1'b1; dsel = F_HOUR;  blk_f = F_HOUR;  end
      5'd23: ch = ASC_H;
      5'd24: begin dig_en = 1'b1; dsel = F_MIN;   blk_f = F_MIN;   end
      5'd25: begin dig_en = 1'b1; dig_ones = 1'b1; dsel = F_MIN;   blk_f = F_MIN;   end
      5'd26: ch = ASC_M;
      5'd27: begin dig_en = 1'b1; dsel = F_SEC;   blk_f = F_SEC;   end
      5'd28: begin dig_en = 1'b1; dig_ones = 1'b1; dsel = F_SEC;   blk_f = F_SEC;   end
      5'd29: ch = ASC_S;
      5'd31: begin ch = ASC_COMMIT; blk_f = SLOT_COMMIT; end
      default: ch = ASC_SPACE;
    endcase

    // Values are < 100, so the tens digit is a plain divide by ten.
    dval  = view[dsel];
    dig_v = dig_ones ? (dval % V_10) : (dval / V_10);
    if (dig_en) begin
      ch = ASC_ZERO + 8'(dig_v);
    end
    if (phase && state == EDIT && blk_f == cursor) begin
      ch = ASC_SPACE;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fld[F_YEAR]  <= V_0;
      fld[F_MONTH] <= V_1;
      fld[F_DAY]   <= V_1;
      fld[F_HOUR]  <= V_0;
      fld[F_MIN]   <= V_0;
      fld[F_SEC]   <= V_0;
      cursor   <= 3'd0;
      bin_time <= '0;
      en_time  <= 1'b0;
      phase    <= 1'b0;
      out      <= ASC_NUL;
    end else begin
      en_time <= do_commit;
      if (do_commit) begin
        bin_time <= fld_packed;
      end

      if (load) begin
        for (int i = 0; i < 6; i++) begin
          fld[i] <= live_f[i];
        end
        cursor <= 3'd0;
      end else if (state == EDIT) begin
        if (act_r && cursor < SLOT_COMMIT) begin
          cursor <= cursor + 3'd1;
        end else if (act_l && cursor != 3'd0) begin
          cursor <= cursor - 3'd1;
        end
        if ((act_u || act_d) && cursor < SLOT_COMMIT) begin
          for (int i = 0; i < 6; i++) begin
            fld[i] <= fld_nx[i];
          end
        end
      end

      // A key action keeps the edited field visible while the user works.
      if (any_act) begin
        phase <= 1'b0;
      end else if (blink_tick) begin
        phase <= ~phase;
      end

      out <= ch;
    end
  end

endmodule

// File: tb/tb_time_field_editor.sv
module tb_time_field_editor;

  localparam int D    = 10;
  localparam int P    = 4;
  localparam int HMAX = 23;

  logic        clk = 1'b0;
  logic        rst, blink_tick, edit_req;
  logic        key_right, key_left, key_up, key_down;
  logic [47:0] live_time, bin_time;
  logic        en_time, editing;
  logic [2:0]  cursor;
  logic [4:0]  index;
  logic [7:0]  out;

  always #5 clk = ~clk;

  time_field_editor #(
    .FIELD_W(8), .REPEAT_DELAY(24'd10), .REPEAT_PERIOD(24'd4), .HOUR_MAX(HMAX)
  ) dut (
    .clk(clk), .rst(rst), .blink_tick(blink_tick), .edit_req(edit_req),
    .live_time(live_time), .key_right(key_right), .key_left(key_left),
    .key_up(key_up), .key_down(key_down), .index(index),
    .bin_time(bin_time), .en_time(en_time), .editing(editing),
    .cursor(cursor), .out(out)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          m_f[6];
  int          m_cur;
  bit          m_edit;
  logic [47:0] m_bin;
  logic [47:0] exp_q[$];
  logic [47:0] mon_e;

  int dim_tab[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
  int dpos[6]     = '{7, 10, 13, 21, 24, 27};

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int mdim(int mon, int yr);
    return dim_tab[mon] + ((mon == 2 && yr % 4 == 0) ? 1 : 0);
  endfunction

  function automatic int f_lo(int f);
    return (f == 1 || f == 2) ? 1 : 0;
  endfunction

  function automatic int f_hi(int f);
    case (f)
      0: return 99;
      1: return 12;
      2: return mdim(m_f[1], m_f[0]);
      3: return HMAX;
      default: return 59;
    endcase
  endfunction

  function automatic logic [47:0] pk(int y, int mo, int d, int h, int mi, int s);
    return {8'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
  endfunction

  function automatic logic [47:0] model_pack();
    return pk(m_f[0], m_f[1], m_f[2], m_f[3], m_f[4], m_f[5]);
  endfunction

  // k: 0 right, 1 left, 2 up, 3 down
  task automatic model_action(int k);
    int lo, hi, v;
    if (!m_edit) return;
    if (k == 0) begin
      if (m_cur < 6) m_cur++;
    end else if (k == 1) begin
      if (m_cur > 0) m_cur--;
    end else if (m_cur == 6) begin
      if (k == 2) begin
        m_bin = model_pack();
        exp_q.push_back(m_bin);
      end
      m_edit = 0;
    end else begin
      lo = f_lo(m_cur);
      hi = f_hi(m_cur);
      v  = m_f[m_cur];
      if (k == 2) v = (v == hi) ? lo : v + 1;
      else        v = (v == lo) ? hi : v - 1;
      m_f[m_cur] = v;
      if (m_cur <= 1 && m_f[2] > mdim(m_f[1], m_f[0])) m_f[2] = mdim(m_f[1], m_f[0]);
    end
  endtask

  function automatic logic [7:0] exp_char(int idx, logic [47:0] tm, int blank);
    string       t = "SET  20..Y..M..DTIME ..H..M..S  ";
    logic [7:0]  c;
    int          grp, v;
    c   = t[idx];
    grp = -1;
    if (idx == 31) begin c = 8'hAE; grp = 6; end
    if (idx == 5 || idx == 6) grp = 0;
    for (int f = 0; f < 6; f++) begin
      v = int'(tm[(5-f)*8 +: 8]);
      if (idx == dpos[f])     begin c = 8'(48 + v / 10); grp = f; end
      if (idx == dpos[f] + 1) begin c = 8'(48 + v % 10); grp = f; end
    end
    if (blank >= 0 && grp == blank) c = 8'h20;
    return c;
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic set_key(int k, logic v);
    case (k)
      0: key_right = v;
      1: key_left  = v;
      2: key_up    = v;
      default: key_down = v;
    endcase
  endtask

  task automatic press(int k);
    set_key(k, 1'b1);
    model_action(k);
    @(posedge clk); #1;
    set_key(k, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic hold(int k, int h);
    set_key(k, 1'b1);
    for (int c = 0; c < h; c++) begin
      if (c == 0 || (c >= D && (c - D) % P == 0)) model_action(k);
      @(posedge clk); #1;
    end
    set_key(k, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic start_edit(int y, int mo, int d, int h, int mi, int s);
    live_time = pk(y, mo, d, h, mi, s);
    edit_req  = 1'b1;
    if (!m_edit) begin
      m_f[0] = y; m_f[1] = mo; m_f[2] = d; m_f[3] = h; m_f[4] = mi; m_f[5] = s;
      m_cur  = 0;
      m_edit = 1;
    end
    @(posedge clk); #1;
    edit_req = 1'b0;
  endtask

  task automatic rand_edit();
    int y, mo;
    y  = $urandom_range(0, 99);
    mo = $urandom_range(1, 12);
    start_edit(y, mo, $urandom_range(1, mdim(mo, y)), $urandom_range(0, HMAX),
               $urandom_range(0, 59), $urandom_range(0, 59));
  endtask

  task automatic finish_session(int k);
    while (m_edit && m_cur < 6) press(0);
    if (m_edit) press(k);
  endtask

  // ---------------------------------------------------------------- commit monitor
  always @(negedge clk) begin
    if (!rst && en_time) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_en_time: bin_time=%0h, no commit pending", bin_time);
      end else begin
        mon_e = exp_q.pop_front();
        check("commit_bin_time", bin_time, mon_e);
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; blink_tick = 1'b0; edit_req = 1'b0;
    key_right = 1'b0; key_left = 1'b0; key_up = 1'b0; key_down = 1'b0;
    live_time = '0; index = 5'd0;
    m_f = '{0, 1, 1, 0, 0, 0}; m_cur = 0; m_edit = 0; m_bin = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", out, 8'h00);
    check("reset_bin_time", bin_time, 48'h0);
    check("reset_en_time", en_time, 1'b0);
    check("reset_editing", editing, 1'b0);
    check("reset_cursor", cursor, 3'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic snapshot + commit, cursor saturation
    start_edit(24, 2, 29, 10, 30, 0);
    check("edit_entered", editing, 1'b1);
    check("edit_cursor0", cursor, 3'd0);
    press(1);
    check("left_sat_0", cursor, 3'd0);
    repeat (6) press(0);
    check("cursor_at_6", cursor, 3'd6);
    press(0);
    check("right_sat_6", cursor, 3'd6);
    press(2);
    check("commit_exit", editing, 1'b0);
    check("commit_value", bin_time, pk(24, 2, 29, 10, 30, 0));

    // year change clamps Feb 29 -> 28
    start_edit(24, 2, 29, 10, 30, 0);
    press(2);
    finish_session(2);
    check("leap_year_clamp", bin_time, pk(25, 2, 28, 10, 30, 0));

    // month down from March 31 in a leap year
    start_edit(24, 3, 31, 12, 0, 0);
    press(0); press(3);
    finish_session(2);
    check("month_down_clamp", bin_time, pk(24, 2, 29, 12, 0, 0));

    // wraps
    start_edit(10, 1, 15, 0, 59, 30);
    press(0); press(3);
    press(0); press(0); press(3);
    press(0); press(2);
    finish_session(2);
    check("wraps", bin_time, pk(10, 12, 15, 23, 0, 30));

    // auto-repeat on seconds, plus simultaneous keys doing nothing
    start_edit(30, 6, 10, 5, 5, 0);
    repeat (5) press(0);
    hold(2, 10);
    hold(2, 11);
    hold(2, 30);
    key_up = 1'b1; key_down = 1'b1;
    repeat (15) @(posedge clk);
    #1; key_up = 1'b0; key_down = 1'b0;
    key_right = 1'b1; key_left = 1'b1;
    repeat (3) @(posedge clk);
    #1; key_right = 1'b0; key_left = 1'b0;
    @(posedge clk); #1;
    check("multi_key_cursor", cursor, 3'd5);
    finish_session(2);
    check("auto_repeat", bin_time, pk(30, 6, 10, 5, 5, 9));

    // cancel leaves bin_time alone
    start_edit(1, 1, 1, 1, 1, 1);
    press(2);
    finish_session(3);
    repeat (2) @(posedge clk);
    #1;
    check("cancel_exit", editing, 1'b0);
    check("cancel_bin_time", bin_time, pk(30, 6, 10, 5, 5, 9));

    // blink / display in edit mode
    start_edit(24, 2, 29, 7, 30, 0);
    repeat (3) press(0);
    index = 5'd21;
    blink_tick = 1'b1; @(posedge clk); #1; blink_tick = 1'b0;
    @(posedge clk); #1;
    check("blank_idx21", out, 8'h20);
    index = 5'd22; @(posedge clk); #1;
    check("blank_idx22", out, 8'h20);
    index = 5'd24; @(posedge clk); #1;
    check("noblank_idx24", out, 8'h33);
    check("edit_idx24_model", out, exp_char(24, model_pack(), 3));
    blink_tick = 1'b1; @(posedge clk); #1; blink_tick = 1'b0;
    index = 5'd22; @(posedge clk); #1;
    check("hour_ones_visible", out, 8'h37);
    blink_tick = 1'b1; key_right = 1'b1; model_action(0);
    @(posedge clk); #1;
    blink_tick = 1'b0; key_right = 1'b0;
    index = 5'd24; @(posedge clk); #1;
    check("action_beats_tick", out, 8'h33);
    finish_session(3);

    // reset in the middle of an edit
    start_edit(50, 5, 5, 5, 5, 5);
    press(2); press(0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_editing", editing, 1'b0);
    check("rst_mid_en_time", en_time, 1'b0);
    check("rst_mid_bin_time", bin_time, 48'h0);
    rst = 1'b0;
    m_f = '{0, 1, 1, 0, 0, 0}; m_cur = 0; m_edit = 0; m_bin = '0;
    @(posedge clk); #1;
    check("rst_mid_cursor", cursor, 3'd0);

    // idle display follows live_time
    for (int i = 0; i < 24; i++) begin
      live_time = pk($urandom_range(0, 99), $urandom_range(1, 12), $urandom_range(1, 31),
                     $urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      index = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      check("idle_display", out, exp_char(int'(index), live_time, -1));
    end

    // randomized sessions
    for (int s = 0; s < 10; s++) begin
      rand_edit();
      for (int op = 0; op < 20; op++) begin
        int r;
        r = $urandom_range(0, 11);
        if (r < 8)        press(r % 4);
        else if (r < 10)  hold($urandom_range(2, 3), $urandom_range(1, 25));
        else if (r == 10) press($urandom_range(0, 1));
        else              rand_edit();
      end
      if (m_edit) finish_session($urandom_range(2, 3));
      repeat (2) @(posedge clk);
      #1;
      check("session_bin_time", bin_time, m_bin);
      check("session_editing", editing, m_edit);
    end

    repeat (5) @(posedge clk);
    #1;
    check("pending_commits", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
